// File: rtl/nibble_window_stats_if.sv
// rtl/nibble_window_stats_if.sv - sample input / window result handshake bundle
interface nibble_window_stats_if #(
    parameter int WINDOW = 8,
    parameter int CNT_W  = $clog2(WINDOW + 1),
    parameter int SUM_W  = 4 + $clog2(WINDOW + 1)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_val;
    logic             in_p;
    logic             in_d;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_prime_cnt;
    logic [CNT_W-1:0] out_div3_cnt;
    logic [CNT_W-1:0] out_both_cnt;
    logic [3:0]       out_max;
    logic [SUM_W-1:0] out_sum;

    // master drives samples and consumes results; slave is the stats stage
    modport master (
        output in_valid, in_val, in_p, in_d, out_ready,
        input  in_ready, out_valid, out_prime_cnt, out_div3_cnt,
               out_both_cnt, out_max, out_sum
    );

    modport slave (
        input  in_valid, in_val, in_p, in_d, out_ready,
        output in_ready, out_valid, out_prime_cnt, out_div3_cnt,
               out_both_cnt, out_max, out_sum
    );
endinterface

// File: rtl/nibble_window_stats.sv
// rtl/nibble_window_stats.sv - per-window prime/div3 counts, max and sum of classified nibbles
module nibble_window_stats #(
    parameter int WINDOW = 8,
    parameter int CNT_W  = $clog2(WINDOW + 1),
    parameter int SUM_W  = 4 + $clog2(WINDOW + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nibble_window_stats_if.slave bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] prime_acc;
    logic [CNT_W-1:0] div3_acc;
    logic [CNT_W-1:0] both_acc;
    logic [3:0]       max_acc;
    logic [SUM_W-1:0] sum_acc;

    logic [CNT_W-1:0] prime_q;
    logic [CNT_W-1:0] div3_q;
    logic [CNT_W-1:0] both_q;
    logic [3:0]       max_q;
    logic [SUM_W-1:0] sum_q;

    logic             in_xfer;
    logic             out_xfer;
    logic             last_sample;
    logic [CNT_W-1:0] prime_nxt;
    logic [CNT_W-1:0] div3_nxt;
    logic [CNT_W-1:0] both_nxt;
    logic [3:0]       max_nxt;
    logic [SUM_W-1:0] sum_nxt;

    // handshakes use the registered flags so acceptance never depends on inputs
    assign in_xfer     = bus.in_valid & in_ready_q;
    assign out_xfer    = out_valid_q & bus.out_ready;
    assign last_sample = (sample_cnt == LAST_IDX);

    // accumulator values including the sample offered this cycle
    assign prime_nxt = prime_acc + CNT_W'(bus.in_p);
    assign div3_nxt  = div3_acc + CNT_W'(bus.in_d);
    assign both_nxt  = both_acc + CNT_W'(bus.in_p & bus.in_d);
    assign max_nxt   = (bus.in_val > max_acc) ? bus.in_val : max_acc;
    assign sum_nxt   = sum_acc + SUM_W'(bus.in_val);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ACCUM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sample_cnt  <= '0;
            prime_acc   <= '0;
            div3_acc    <= '0;
            both_acc    <= '0;
            max_acc     <= '0;
            sum_acc     <= '0;
            prime_q     <= '0;
            div3_q      <= '0;
            both_q      <= '0;
            max_q       <= '0;
            sum_q       <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    // ready is held low for the reset cycle, then opens here
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        if (last_sample) begin
                            prime_q     <= prime_nxt;
                            div3_q      <= div3_nxt;
                            both_q      <= both_nxt;
                            max_q       <= max_nxt;
                            sum_q       <= sum_nxt;
                            prime_acc   <= '0;
                            div3_acc    <= '0;
                            both_acc    <= '0;
                            max_acc     <= '0;
                            sum_acc     <= '0;
                            sample_cnt  <= '0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            prime_acc  <= prime_nxt;
                            div3_acc   <= div3_nxt;
                            both_acc   <= both_nxt;
                            max_acc    <= max_nxt;
                            sum_acc    <= sum_nxt;
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state       <= ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_prime_cnt = prime_q;
    assign bus.out_div3_cnt  = div3_q;
    assign bus.out_both_cnt  = both_q;
    assign bus.out_max       = max_q;
    assign bus.out_sum       = sum_q;
endmodule
